data_reg_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-bit output data register among P_NUM_REQ requesters.
- Each requester presents a request and an 8-bit data byte.
- The arbiter grants one requester at a time, loads that byte into DATA_O, and then holds the resource busy for a programmable number of cycles before arbitrating again.
- It sits in front of the downstream consumer of DATA_O (e.g. MOD2/MOD3-style sub-blocks) and sequences all writes to that register.

---
 rtl/data_reg_arbiter_if.sv | 24 ++
 rtl/data_reg_arbiter.sv | 109 ++++++++++
 tb/tb_data_reg_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_reg_arbiter_if.sv
// Request/data bus between the requesters and the shared data-register arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface data_reg_arbiter_if #(
  parameter int P_NUM_REQ = 4,
  parameter int P_ID_W    = 3
);
  logic [P_NUM_REQ-1:0]   REQ_I;
  logic [8*P_NUM_REQ-1:0] DATA_I;
  logic [7:0]             DATA_O;
  logic [P_NUM_REQ-1:0]   GNT_O;
  logic [P_ID_W-1:0]      GNT_ID_O;
  logic                   VALID_O;
  logic                   BUSY_O;

  modport master (
    output REQ_I, DATA_I,
    input  DATA_O, GNT_O, GNT_ID_O, VALID_O, BUSY_O
  );

  modport slave (
    input  REQ_I, DATA_I,
    output DATA_O, GNT_O, GNT_ID_O, VALID_O, BUSY_O
  );
endinterface

// File: rtl/data_reg_arbiter.sv
// Round-robin arbiter sequencing writes from P_NUM_REQ requesters into one
// 8-bit register, with a fixed busy window after every grant.
module data_reg_arbiter #(
  parameter int         P_NUM_REQ     = 4,
  parameter int         P_HOLD_CYCLES = 2,
  parameter logic [7:0] P_RESET_VAL   = 8'h00,
  parameter int         P_ID_W        = 3
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  data_reg_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  logic [P_ID_W-1:0]   r_ptr;
  logic [3:0]          r_cnt;
  logic [7:0]          r_data;
  logic [P_NUM_REQ-1:0] r_gnt;
  logic [P_ID_W-1:0]   r_gnt_id;
  logic                r_valid;
  logic                r_busy;

  logic                w_found;
  logic [P_ID_W-1:0]   w_win;
  int                  w_idx;

  // Search starts just past the last winner so the previous grantee ranks last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int i = 1; i <= P_NUM_REQ; i++) begin
      w_idx = (int'(r_ptr) + i) % P_NUM_REQ;
      if (!w_found && bus.REQ_I[w_idx]) begin
        w_found = 1'b1;
        w_win   = P_ID_W'(w_idx);
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state  <= S_IDLE;
      r_ptr    <= P_ID_W'(P_NUM_REQ - 1);
      r_cnt    <= '0;
      r_data   <= P_RESET_VAL;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_gnt   <= '0;
          r_valid <= 1'b0;
          if (w_found) begin
            r_data   <= bus.DATA_I[8*int'(w_win) +: 8];
            r_gnt    <= P_NUM_REQ'(1) << w_win;
            r_gnt_id <= w_win;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_ptr    <= w_win;
            r_state  <= S_GRANT;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_GRANT: begin
          r_gnt   <= '0;
          r_valid <= 1'b0;
          if (P_HOLD_CYCLES > 0) begin
            r_cnt   <= 4'(P_HOLD_CYCLES);
            r_state <= S_HOLD;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (r_cnt == 4'd1) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.DATA_O   = r_data;
  assign bus.GNT_O    = r_gnt;
  assign bus.GNT_ID_O = r_gnt_id;
  assign bus.VALID_O  = r_valid;
  assign bus.BUSY_O   = r_busy;

endmodule

// File: tb/tb_data_reg_arbiter.sv
// Bench for data_reg_arbiter: two instances (hold 2 and hold 0) share one
// stimulus stream and are checked against a countdown-based reference model.
module tb_data_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  r_req;
  logic [31:0] r_dat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_reg_arbiter_if #(.P_NUM_REQ(4), .P_ID_W(3)) if0 ();
  data_reg_arbiter_if #(.P_NUM_REQ(4), .P_ID_W(3)) if1 ();

  assign if0.REQ_I  = r_req;
  assign if0.DATA_I = r_dat;
  assign if1.REQ_I  = r_req;
  assign if1.DATA_I = r_dat;

  data_reg_arbiter #(.P_NUM_REQ(4), .P_HOLD_CYCLES(2), .P_RESET_VAL(8'h00), .P_ID_W(3))
    dut0 (.CLK_I(clk), .RST_I(rst), .bus(if0));
  data_reg_arbiter #(.P_NUM_REQ(4), .P_HOLD_CYCLES(0), .P_RESET_VAL(8'h00), .P_ID_W(3))
    dut1 (.CLK_I(clk), .RST_I(rst), .bus(if1));

  logic [7:0] d_data [2];
  logic [3:0] d_gnt  [2];
  logic [2:0] d_id   [2];
  logic       d_vld  [2];
  logic       d_busy [2];
  assign d_data[0] = if0.DATA_O;   assign d_data[1] = if1.DATA_O;
  assign d_gnt[0]  = if0.GNT_O;    assign d_gnt[1]  = if1.GNT_O;
  assign d_id[0]   = if0.GNT_ID_O; assign d_id[1]   = if1.GNT_ID_O;
  assign d_vld[0]  = if0.VALID_O;  assign d_vld[1]  = if1.VALID_O;
  assign d_busy[0] = if0.BUSY_O;   assign d_busy[1] = if1.BUSY_O;

  // Reference model: m_left counts remaining busy cycles after a grant.
  logic [7:0] m_data [2];
  logic [3:0] m_gnt  [2];
  logic [2:0] m_id   [2];
  logic       m_vld  [2];
  logic       m_busy [2];
  int         m_ptr  [2];
  int         m_left [2];
  bit         chk_en = 1'b0;

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int i = 1; i <= 4; i++)
      if (req[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int hold;
      int w;
      hold = (k == 0) ? 2 : 0;
      m_gnt[k] = 4'b0;
      m_vld[k] = 1'b0;
      if (rst) begin
        m_data[k] = 8'h00; m_id[k] = 3'd0; m_busy[k] = 1'b0;
        m_ptr[k] = 3; m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
        m_busy[k] = (m_left[k] > 0);
      end else begin
        w = pick(r_req, m_ptr[k]);
        if (w >= 0) begin
          m_data[k] = r_dat[8*w +: 8];
          m_gnt[k]  = 4'(1 << w);
          m_id[k]   = 3'(w);
          m_vld[k]  = 1'b1;
          m_busy[k] = 1'b1;
          m_ptr[k]  = w;
          m_left[k] = 1 + hold;
        end else begin
          m_busy[k] = 1'b0;
        end
      end
    end
    chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (d_data[k] !== m_data[k] || d_gnt[k] !== m_gnt[k] || d_id[k] !== m_id[k] ||
            d_vld[k] !== m_vld[k] || d_busy[k] !== m_busy[k]) begin
          bad++;
          $display("FAIL model_cmp inst%0d t=%0t got data=%h gnt=%b id=%0d vld=%b busy=%b want data=%h gnt=%b id=%0d vld=%b busy=%b",
                   k, $time, d_data[k], d_gnt[k], d_id[k], d_vld[k], d_busy[k],
                   m_data[k], m_gnt[k], m_id[k], m_vld[k], m_busy[k]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Waits for a VALID pulse on instance 0; returns cycles waited, or -1 on timeout.
  task automatic wait_grant0(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (if0.VALID_O === 1'b1) begin
        cyc = i;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL grant_timeout got=none want=grant");
  endtask

  initial begin
    int cyc;
    int g3;
    rst = 1'b1; r_req = 4'b0; r_dat = 32'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_data", int'(if0.DATA_O), 8'h00);
    chk("rst_gnt", int'(if0.GNT_O), 0);
    chk("rst_id", int'(if0.GNT_ID_O), 0);
    chk("rst_valid", int'(if0.VALID_O), 0);
    chk("rst_busy", int'(if0.BUSY_O), 0);

    // Single request from requester 2
    r_req = 4'b0100; r_dat = 32'h0011_0000;
    step();
    chk("single_gnt", int'(if0.GNT_O), 4'b0100);
    chk("single_valid", int'(if0.VALID_O), 1);
    chk("single_data", int'(if0.DATA_O), 8'h11);
    chk("single_id", int'(if0.GNT_ID_O), 2);
    r_req = 4'b0;
    step(); chk("single_busy1", int'(if0.BUSY_O), 1);
    step(); chk("single_busy2", int'(if0.BUSY_O), 1);
    step(); chk("single_busy3", int'(if0.BUSY_O), 0);
    step(); chk("single_hold_data", int'(if0.DATA_O), 8'h11);

    // Full contention from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    r_req = 4'b1111; r_dat = 32'hA3A2_A1A0;
    for (int g = 0; g < 5; g++) begin
      wait_grant0(cyc);
      chk("rr_id", int'(if0.GNT_ID_O), g % 4);
      chk("rr_data", int'(if0.DATA_O), 8'hA0 + (g % 4));
      if (g > 0) chk("rr_spacing", cyc, 4);
    end

    // Pointer rotation: last grant to 1, then 0 and 1 both request
    r_req = 4'b0010;
    wait_grant0(cyc);
    chk("rot_pre_id", int'(if0.GNT_ID_O), 1);
    r_req = 4'b0011;
    wait_grant0(cyc);
    chk("rot_first", int'(if0.GNT_ID_O), 0);
    wait_grant0(cyc);
    chk("rot_second", int'(if0.GNT_ID_O), 1);
    r_req = 4'b0;
    step(); step(); step(); step();

    // Reset during the second HOLD cycle
    r_req = 4'b1000; r_dat = 32'h5500_0000;
    wait_grant0(cyc);
    r_req = 4'b0;
    step(); step();
    rst = 1'b1; r_req = 4'b1010; r_dat = 32'h0000_7700;
    step();
    chk("midrst_busy", int'(if0.BUSY_O), 0);
    chk("midrst_data", int'(if0.DATA_O), 8'h00);
    rst = 1'b0;
    step();
    chk("midrst_next_id", int'(if0.GNT_ID_O), 1);
    chk("midrst_next_gnt", int'(if0.GNT_O), 4'b0010);
    chk("midrst_next_data", int'(if0.DATA_O), 8'h77);

    // Zero-hold instance: held request pulses every other cycle
    rst = 1'b1; r_req = 4'b0; step(); rst = 1'b0;
    r_req = 4'b0001; r_dat = 32'h0000_0033;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("h0_gnt", int'(if1.GNT_O), (i % 2 == 0) ? 1 : 0);
    end

    // Masked pulse: requester 3 asserts only while instance 0 is busy
    rst = 1'b1; r_req = 4'b0; step(); rst = 1'b0;
    r_req = 4'b0001;
    step();
    chk("mask_first", int'(if0.GNT_ID_O), 0);
    r_req = 4'b1000;
    step();
    r_req = 4'b0;
    g3 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if0.VALID_O === 1'b1) g3++;
    end
    chk("mask_no_grant", g3, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      r_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r_req = 4'b0;
      r_dat = $urandom;
      rst   = ($urandom_range(0, 60) == 0);
      step();
    end
    rst = 1'b0; r_req = 4'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
